xmodem_imem_loader: RTL and testbench
=====================================

# xmodem_imem_loader

Boot-time controller between UART0 and the CPU subsystem's instruction-memory write port. Receives a program from the host as an XMODEM (checksum variant) transfer. Assembles little-endian 32-bit words into instruction memory, then ACKs or NAKs each block. After EOT it waits for the host run command and only then enables the pipeline.

## Interface
- NB_UART_DATA, 8, UART byte width
- NB_INSTRUCTION, 32, instruction word width
- IMEM_ADDR_WIDTH, 6, instruction-memory word-address width (depth 2^6 words)
- clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_uart_rx_data  in  NB_UART_DATA  head of UART RX FIFO, valid combinationally
- i_uart_rx_done  in  1  one-cycle pulse per received byte
- i_uart_tx_done  in  1  one-cycle pulse when a transmitted byte leaves the line
- o_uart_rd  out  1  one-cycle pop of RX FIFO; byte consumed in that same cycle
- o_uart_wr  out  1  one-cycle push of o_uart_wdata into TX FIFO
- o_uart_wdata  out  NB_UART_DATA  reply byte (ACK 0x06 / NAK 0x15)
- o_uart_tx_start  out  1  one-cycle transmit start, cycle after o_uart_wr
- o_imem_we  out  1  one-cycle instruction-memory write strobe
- o_imem_addr  out  IMEM_ADDR_WIDTH  word address
- o_imem_wdata  out  NB_INSTRUCTION  assembled word
- o_load_done  out  1  level; EOT accepted and ACKed
- o_overflow  out  1  sticky; a word address exceeded depth
- o_cpu_en  out  1  level; CPU run enable, held until reset or CAN

## Operation
- Pending counter: +1 per i_uart_rx_done pulse, −1 per o_uart_rd. A simultaneous +1 and −1 leaves it unchanged. Width 3 bits, saturating.
- Consume a byte (o_uart_rd=1) whenever pending≠0 and the FSM is not in TX_WR or TX_WAIT.
- FSM states: IDLE, BLK, BLKN, DATA, CKSUM, TX_WR, TX_WAIT, LOADED.
- IDLE:
  - SOT 0x01 → BLK.
  - EOT 0x04 → reply ACK, set o_load_done, then LOADED.
  - CAN 0x18 → base=0, stay IDLE.
  - Any other byte is ignored.
- BLK: latch the block number → BLKN.
- BLKN: header is good when byte == ~blk. Either way → DATA with byte index 0 and checksum 0.
- DATA: 128 bytes.
  - checksum += byte, mod 256.
  - Byte k goes into word lane k%4, lane 0 = bits [7:0].
  - On lane 3, pulse o_imem_we with addr = base + k/4.
  - After byte 127 → CKSUM.
- CKSUM: block is good when header good AND received byte == checksum AND blk == expected.
  - Good block: base += 32, expected += 1, reply ACK.
  - Duplicate (blk == expected−1, header good): reply ACK, base unchanged.
  - Otherwise: reply NAK, base unchanged. The sender resends and overwrites the same words.
- TX_WR: o_uart_wr=1 with wdata, then TX_WAIT.
- TX_WAIT: o_uart_tx_start=1 on entry cycle. Wait for i_uart_tx_done, then return to IDLE (or LOADED after EOT).
- LOADED:
  - 0x01 → o_cpu_en=1.
  - CAN → clear o_load_done, o_cpu_en, base, expected=1; go to IDLE.
  - Other bytes ignored.
- Overflow: a word address ≥ 2^IMEM_ADDR_WIDTH suppresses o_imem_we and sets o_overflow. The block is still ACKed if its checksum is good.
- Block number is 8 bits and wraps 0xFF→0x00. Base uses IMEM_ADDR_WIDTH+1 bits so overflow is detectable.

## Timing
- Reset (async, i_rst_n=0):
  - All outputs 0.
  - FSM=IDLE, base=0, expected=1, pending=0, checksum=0, o_overflow=0.
- Reset mid-transfer or mid-reply aborts immediately. The partially written block stays in imem.
- Byte consume latency: o_uart_rd asserts one cycle after i_uart_rx_done when pending was 0.
- Word write: o_imem_we, addr and wdata are registered and valid in the cycle after the lane-3 byte is consumed.
- Reply: o_uart_wr one cycle after the CKSUM (or EOT) byte; o_uart_tx_start the next cycle.
- No byte is consumed between o_uart_wr and i_uart_tx_done. RX bytes queue in the pending counter and FIFO meanwhile.
- o_cpu_en rises one cycle after the 0x01 byte is consumed in LOADED.

## Structure
- Shared package xmodem_pkg holds:
  - SOT/EOT/ACK/NAK/CAN constants;
  - block size 128;
  - the FSM state enum.
- One natural sub-module, xmodem_reply_tx: takes a byte request, drives the wr → tx_start → wait-done handshake, and returns busy. Everything else stays in a single FSM module.

## Test plan
- Good single block: 0x01, 0x01, 0xFE, then 11 words. Words are 0x00C00093, 0xFFF00113, … (addi x1,x0,0xC first), then 84×0x1A padding, correct checksum, EOT. Required: ACK, ACK; imem[0]=0x00C00093; 32 write strobes; o_load_done=1; o_cpu_en=0.
- Run command: after the case above, send 0x01 → o_cpu_en=1 one cycle after consume; a further 0x01 leaves it at 1.
- Bad checksum: same block with checksum+1 → NAK, base stays 0. Resend correctly → ACK, imem[0..10] correct, next block written at word 32.
- Bad header: blk=0x01, ~blk=0xFF → NAK after 128 data bytes plus checksum; expected stays 1.
- Overflow and duplicate: three good blocks. The third sets o_overflow with no strobes beyond word 63 and is ACKed. Resending block 3 → ACK, base unchanged.
- Async reset in DATA at byte 50 → all outputs 0 immediately. A fresh SOT transfer then loads from word 0.

Source files
------------

// File: rtl/xmodem_pkg.sv
// Shared constants and state types for the XMODEM instruction-memory loader.
package xmodem_pkg;

    localparam logic [7:0] SOT = 8'h01;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] CAN = 8'h18;

    localparam int BLOCK_BYTES = 128;

    typedef enum logic [2:0] {
        IDLE,
        BLK,
        BLKN,
        DATA,
        CKSUM,
        TX_WR,
        TX_WAIT,
        LOADED
    } state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WR,
        R_START,
        R_WAIT
    } reply_state_e;

endpackage

// File: rtl/xmodem_reply_tx.sv
// Reply sender: pushes one byte into the UART TX FIFO, starts transmission
// and stays busy until the byte has left the line.
module xmodem_reply_tx
    import xmodem_pkg::*;
#(
    parameter int NB_UART_DATA = 8
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_req,
    input  logic [NB_UART_DATA-1:0] i_byte,
    input  logic                    i_uart_tx_done,
    output logic                    o_uart_wr,
    output logic [NB_UART_DATA-1:0] o_uart_wdata,
    output logic                    o_uart_tx_start,
    output logic                    o_busy
);

    reply_state_e            state_q, state_d;
    logic [NB_UART_DATA-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= R_IDLE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        case (state_q)
            R_IDLE: begin
                if (i_req) begin
                    state_d = R_WR;
                    wdata_d = i_byte;
                end
            end
            R_WR:    state_d = R_START;
            R_START: state_d = i_uart_tx_done ? R_IDLE : R_WAIT;
            R_WAIT:  if (i_uart_tx_done) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    assign o_uart_wr       = (state_q == R_WR);
    assign o_uart_tx_start = (state_q == R_START);
    assign o_uart_wdata    = wdata_q;
    assign o_busy          = (state_q != R_IDLE);

endmodule

// File: rtl/xmodem_imem_loader.sv
// Boot loader: receives an XMODEM (checksum) transfer from the UART, writes
// little-endian words into instruction memory and enables the CPU on command.
module xmodem_imem_loader
    import xmodem_pkg::*;
#(
    parameter int NB_UART_DATA    = 8,
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
    input  logic                       i_uart_rx_done,
    input  logic                       i_uart_tx_done,
    output logic                       o_uart_rd,
    output logic                       o_uart_wr,
    output logic [NB_UART_DATA-1:0]    o_uart_wdata,
    output logic                       o_uart_tx_start,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
    output logic                       o_load_done,
    output logic                       o_overflow,
    output logic                       o_cpu_en
);

    localparam int AW1 = IMEM_ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] BLK_WORDS = AW1'(BLOCK_BYTES / 4);
    localparam logic [6:0]     LAST_IDX  = 7'(BLOCK_BYTES - 1);

    state_e                                 state_q, state_d;
    logic [2:0]                             pend_q, pend_d;
    logic [AW1-1:0]                         base_q, base_d;
    logic [7:0]                             exp_q, exp_d;
    logic [7:0]                             blk_q, blk_d;
    logic [NB_UART_DATA-1:0]                csum_q, csum_d;
    logic                                   hdr_ok_q, hdr_ok_d;
    logic [6:0]                             idx_q, idx_d;
    logic [NB_INSTRUCTION-NB_UART_DATA-1:0] word_q, word_d;
    logic                                   imem_we_q, imem_we_d;
    logic [IMEM_ADDR_WIDTH-1:0]             imem_addr_q, imem_addr_d;
    logic [NB_INSTRUCTION-1:0]              imem_wdata_q, imem_wdata_d;
    logic                                   load_done_q, load_done_d;
    logic                                   overflow_q, overflow_d;
    logic                                   cpu_en_q, cpu_en_d;
    logic                                   ret_loaded_q, ret_loaded_d;

    logic                    rd;
    logic                    reply_req;
    logic [NB_UART_DATA-1:0] reply_byte;
    logic                    reply_busy;
    logic [AW1-1:0]          waddr;
    logic                    good_blk;
    logic                    dup_blk;

    // Bytes are never consumed while a reply is in flight; they queue in the FIFO.
    assign rd       = (pend_q != 3'd0) && (state_q != TX_WR) && (state_q != TX_WAIT);
    assign waddr    = base_q + AW1'(idx_q[6:2]);
    assign good_blk = hdr_ok_q && (i_uart_rx_data == csum_q) && (blk_q == exp_q);
    assign dup_blk  = hdr_ok_q && (blk_q == (exp_q - 8'd1));

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            base_q       <= '0;
            exp_q        <= 8'd1;
            blk_q        <= '0;
            csum_q       <= '0;
            hdr_ok_q     <= 1'b0;
            idx_q        <= '0;
            word_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            cpu_en_q     <= 1'b0;
            ret_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            base_q       <= base_d;
            exp_q        <= exp_d;
            blk_q        <= blk_d;
            csum_q       <= csum_d;
            hdr_ok_q     <= hdr_ok_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            load_done_q  <= load_done_d;
            overflow_q   <= overflow_d;
            cpu_en_q     <= cpu_en_d;
            ret_loaded_q <= ret_loaded_d;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (i_uart_rx_done && !rd) begin
            if (pend_q != 3'd7) pend_d = pend_q + 3'd1;
        end else if (!i_uart_rx_done && rd) begin
            pend_d = pend_q - 3'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        exp_d        = exp_q;
        blk_d        = blk_q;
        csum_d       = csum_q;
        hdr_ok_d     = hdr_ok_q;
        idx_d        = idx_q;
        word_d       = word_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        load_done_d  = load_done_q;
        overflow_d   = overflow_q;
        cpu_en_d     = cpu_en_q;
        ret_loaded_d = ret_loaded_q;
        reply_req    = 1'b0;
        reply_byte   = ACK;

        case (state_q)
            IDLE: begin
                if (rd) begin
                    if (i_uart_rx_data == SOT) begin
                        state_d = BLK;
                    end else if (i_uart_rx_data == EOT) begin
                        reply_req    = 1'b1;
                        load_done_d  = 1'b1;
                        ret_loaded_d = 1'b1;
                        state_d      = TX_WR;
                    end else if (i_uart_rx_data == CAN) begin
                        base_d = '0;
                    end
                end
            end
            BLK: begin
                if (rd) begin
                    blk_d   = i_uart_rx_data;
                    state_d = BLKN;
                end
            end
            BLKN: begin
                if (rd) begin
                    hdr_ok_d = (i_uart_rx_data == ~blk_q);
                    idx_d    = '0;
                    csum_d   = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (rd) begin
                    csum_d = csum_q + i_uart_rx_data;
                    idx_d  = idx_q + 7'd1;
                    case (idx_q[1:0])
                        2'd0: word_d[7:0]   = i_uart_rx_data;
                        2'd1: word_d[15:8]  = i_uart_rx_data;
                        2'd2: word_d[23:16] = i_uart_rx_data;
                        default: begin
                            // Words past the end of imem are dropped but flagged.
                            if (waddr[AW1-1]) begin
                                overflow_d = 1'b1;
                            end else begin
                                imem_we_d    = 1'b1;
                                imem_addr_d  = waddr[IMEM_ADDR_WIDTH-1:0];
                                imem_wdata_d = {i_uart_rx_data, word_q};
                            end
                        end
                    endcase
                    if (idx_q == LAST_IDX) state_d = CKSUM;
                end
            end
            CKSUM: begin
                if (rd) begin
                    reply_req    = 1'b1;
                    ret_loaded_d = 1'b0;
                    state_d      = TX_WR;
                    if (good_blk) begin
                        base_d = base_q + BLK_WORDS;
                        exp_d  = exp_q + 8'd1;
                    end else if (!dup_blk) begin
                        reply_byte = NAK;
                    end
                end
            end
            TX_WR: state_d = TX_WAIT;
            TX_WAIT: begin
                if (!reply_busy) state_d = ret_loaded_q ? LOADED : IDLE;
            end
            LOADED: begin
                if (rd) begin
                    if (i_uart_rx_data == SOT) begin
                        cpu_en_d = 1'b1;
                    end else if (i_uart_rx_data == CAN) begin
                        load_done_d = 1'b0;
                        cpu_en_d    = 1'b0;
                        base_d      = '0;
                        exp_d       = 8'd1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    xmodem_reply_tx #(
        .NB_UART_DATA(NB_UART_DATA)
    ) u_reply_tx (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_req          (reply_req),
        .i_byte         (reply_byte),
        .i_uart_tx_done (i_uart_tx_done),
        .o_uart_wr      (o_uart_wr),
        .o_uart_wdata   (o_uart_wdata),
        .o_uart_tx_start(o_uart_tx_start),
        .o_busy         (reply_busy)
    );

    assign o_uart_rd    = rd;
    assign o_imem_we    = imem_we_q;
    assign o_imem_addr  = imem_addr_q;
    assign o_imem_wdata = imem_wdata_q;
    assign o_load_done  = load_done_q;
    assign o_overflow   = overflow_q;
    assign o_cpu_en     = cpu_en_q;

endmodule

// File: tb/tb_xmodem_imem_loader.sv
// Directed/randomized bench for the XMODEM loader with a block-level reference model.
module tb_xmodem_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_done;
    logic        uart_rd;
    logic        uart_wr;
    logic [7:0]  uart_wdata;
    logic        tx_start;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        load_done;
    logic        overflow;
    logic        cpu_en;

    always #5 clk = ~clk;

    xmodem_imem_loader dut (
        .clk            (clk),
        .i_rst_n        (rst_n),
        .i_uart_rx_data (rx_data),
        .i_uart_rx_done (rx_done),
        .i_uart_tx_done (tx_done),
        .o_uart_rd      (uart_rd),
        .o_uart_wr      (uart_wr),
        .o_uart_wdata   (uart_wdata),
        .o_uart_tx_start(tx_start),
        .o_imem_we      (imem_we),
        .o_imem_addr    (imem_addr),
        .o_imem_wdata   (imem_wdata),
        .o_load_done    (load_done),
        .o_overflow     (overflow),
        .o_cpu_en       (cpu_en)
    );

    // RX FIFO seen by the DUT: head byte is combinational, popped on o_uart_rd.
    logic [7:0] fifo [1024];
    logic [9:0] wr_ptr;
    logic [9:0] rd_ptr;
    assign rx_data = fifo[rd_ptr];

    always @(posedge clk) begin
        if (!rst_n)       rd_ptr <= wr_ptr;
        else if (uart_rd) rd_ptr <= rd_ptr + 10'd1;
    end

    // Observed instruction memory and strobe log.
    logic [31:0] cap_mem [64];
    int          addr_log [4096];
    int          total_strobes = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            cap_mem[imem_addr]       <= imem_wdata;
            addr_log[total_strobes]  <= int'(imem_addr);
            total_strobes            <= total_strobes + 1;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [64];
    int          ref_base;
    logic [7:0]  ref_exp;
    logic        ref_ovf;
    logic [7:0]  bd [128];

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] PROG [11] = '{
        32'h00C00093, 32'hFFF00113, 32'h002081B3, 32'h40208233, 32'h0020F2B3,
        32'h0020E333, 32'h0020C3B3, 32'h00209433, 32'h0020D4B3, 32'h00102023,
        32'h0000006F
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        fifo[wr_ptr] = b;
        wr_ptr = wr_ptr + 10'd1;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_reply(output logic [7:0] r);
        int n;
        n = 0;
        r = 8'h00;
        while (!uart_wr && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reply_seen", {31'd0, uart_wr}, 32'd1);
        if (uart_wr) begin
            r = uart_wdata;
            @(negedge clk);
            check("tx_start", {31'd0, tx_start}, 32'd1);
            repeat (3) @(negedge clk);
            check("rd_held", {31'd0, uart_rd}, 32'd0);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (cap_mem[i] !== ref_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    // Sends one block with the given header and checksum offset, checks against the model.
    task automatic run_block(input string tag, input logic [7:0] blk, input logic [7:0] blkn,
                             input logic [7:0] ck_delta);
        logic [7:0] sum, ck, r, em1, exp_reply;
        int         exp_n, exp_first, snap;
        logic       hdr;
        sum = 8'd0;
        for (int i = 0; i < 128; i++) sum = sum + bd[i];
        ck        = sum + ck_delta;
        hdr       = (blkn == ~blk);
        exp_n     = 0;
        exp_first = ref_base;
        for (int w = 0; w < 32; w++) begin
            if (ref_base + w < 64) begin
                ref_mem[ref_base + w] = {bd[4*w+3], bd[4*w+2], bd[4*w+1], bd[4*w]};
                exp_n++;
            end else begin
                ref_ovf = 1'b1;
            end
        end
        em1 = ref_exp - 8'd1;
        if (hdr && ck == sum && blk == ref_exp) begin
            exp_reply = 8'h06;
            ref_base  = ref_base + 32;
            ref_exp   = ref_exp + 8'd1;
        end else if (hdr && blk == em1) begin
            exp_reply = 8'h06;
        end else begin
            exp_reply = 8'h15;
        end
        snap = total_strobes;
        send_byte(8'h01);
        send_byte(blk);
        send_byte(blkn);
        for (int i = 0; i < 128; i++) send_byte(bd[i]);
        send_byte(ck);
        wait_reply(r);
        check({tag, "_reply"}, {24'd0, r}, {24'd0, exp_reply});
        check({tag, "_strobes"}, total_strobes - snap, exp_n);
        if (exp_n > 0) check({tag, "_first_addr"}, addr_log[snap], exp_first);
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ref_ovf});
        check_mem({tag, "_imem"});
    endtask

    task automatic fill_random();
        for (int i = 0; i < 128; i++) bd[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        logic [7:0] r;
        rst_n   = 1'b0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        wr_ptr  = 10'd0;
        for (int i = 0; i < 1024; i++) fifo[i] = 8'h00;
        for (int i = 0; i < 64; i++) begin
            cap_mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        ref_base = 0;
        ref_exp  = 8'd1;
        ref_ovf  = 1'b0;

        #1;
        check("rst_uart_rd",  {31'd0, uart_rd},  32'd0);
        check("rst_uart_wr",  {31'd0, uart_wr},  32'd0);
        check("rst_imem_we",  {31'd0, imem_we},  32'd0);
        check("rst_load_done",{31'd0, load_done},32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_cpu_en",   {31'd0, cpu_en},   32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Program block: 11 instructions then SUB padding.
        for (int w = 0; w < 11; w++)
            for (int b = 0; b < 4; b++) bd[4*w+b] = PROG[w][8*b +: 8];
        for (int i = 44; i < 128; i++) bd[i] = 8'h1A;
        run_block("prog", 8'h01, 8'hFE, 8'd0);
        check("imem0_addi", cap_mem[0], 32'h00C00093);

        send_byte(8'h04);
        wait_reply(r);
        check("eot_reply", {24'd0, r}, 32'h06);
        check("eot_load_done", {31'd0, load_done}, 32'd1);
        check("eot_cpu_en", {31'd0, cpu_en}, 32'd0);

        send_byte(8'h01);
        check("run_consume", {31'd0, uart_rd}, 32'd1);
        check("run_cpu_en_pre", {31'd0, cpu_en}, 32'd0);
        @(negedge clk);
        check("run_cpu_en", {31'd0, cpu_en}, 32'd1);
        send_byte(8'h01);
        repeat (3) @(negedge clk);
        check("run_again_cpu_en", {31'd0, cpu_en}, 32'd1);

        send_byte(8'h18);
        repeat (2) @(negedge clk);
        ref_base = 0;
        ref_exp  = 8'd1;
        check("can_load_done", {31'd0, load_done}, 32'd0);
        check("can_cpu_en", {31'd0, cpu_en}, 32'd0);

        fill_random();
        run_block("bad_hdr", 8'h01, 8'hFF, 8'd0);
        run_block("bad_ck", 8'h01, 8'hFE, 8'd1);
        run_block("resend1", 8'h01, 8'hFE, 8'd0);
        fill_random();
        run_block("blk2", 8'h02, 8'hFD, 8'd0);
        fill_random();
        run_block("blk3_ovf", 8'h03, 8'hFC, 8'd0);
        run_block("blk3_dup", 8'h03, 8'hFC, 8'd0);
        fill_random();
        run_block("blk4", 8'h04, 8'hFB, 8'd0);

        // CAN from IDLE rewinds the write base only; then abort a block by reset.
        send_byte(8'h18);
        repeat (2) @(negedge clk);
        ref_base = 0;
        fill_random();
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'hFE);
        for (int i = 0; i < 50; i++) send_byte(bd[i]);
        @(negedge clk);
        for (int w = 0; w < 12; w++)
            ref_mem[w] = {bd[4*w+3], bd[4*w+2], bd[4*w+1], bd[4*w]};
        #1 rst_n = 1'b0;
        #1;
        check("arst_uart_rd",  {31'd0, uart_rd},  32'd0);
        check("arst_uart_wr",  {31'd0, uart_wr},  32'd0);
        check("arst_tx_start", {31'd0, tx_start}, 32'd0);
        check("arst_imem_we",  {31'd0, imem_we},  32'd0);
        check("arst_overflow", {31'd0, overflow}, 32'd0);
        check("arst_wdata",    imem_wdata,        32'd0);
        check_mem("arst_partial_imem");
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ref_base = 0;
        ref_exp  = 8'd1;
        ref_ovf  = 1'b0;
        repeat (2) @(negedge clk);
        fill_random();
        run_block("post_rst", 8'h01, 8'hFE, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
